// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up and special cases in a final cycle.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t state, state_nxt;

   logic [2:0]        op_q;
   logic              sign_a, sign_b, b_zero, ovf;
   logic [XLEN-1:0]   a_q, mag_b, quo;
   logic [XLEN:0]     rem;
   logic [2*XLEN-1:0] prod;
   logic [CW-1:0]     cnt;

   // operand decode for the start edge
   logic              a_signed, b_signed, sa_in, sb_in;
   logic [XLEN-1:0]   mag_a_in, mag_b_in;

   always_comb begin
      a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      sa_in    = a_signed & a[XLEN-1];
      sb_in    = b_signed & b[XLEN-1];
      mag_a_in = sa_in ? -a : a;
      mag_b_in = sb_in ? -b : b;
   end

   // one iteration of each datapath
   logic [XLEN:0]     add_sum;
   logic [2*XLEN-1:0] prod_step;
   logic [XLEN:0]     rem_sh;
   logic [XLEN+1:0]   diff;
   logic              fit;
   logic [XLEN:0]     rem_step;
   logic [XLEN-1:0]   quo_step;

   always_comb begin
      add_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, mag_b};
      prod_step = prod[0] ? {add_sum, prod[XLEN-1:1]} : {1'b0, prod[2*XLEN-1:1]};
      // quo holds the unconsumed dividend bits at the top and the quotient at the bottom
      rem_sh    = {rem[XLEN-1:0], quo[XLEN-1]};
      diff      = {1'b0, rem_sh} - {2'b00, mag_b};
      fit       = ~diff[XLEN+1];
      rem_step  = fit ? diff[XLEN:0] : rem_sh;
      quo_step  = {quo[XLEN-2:0], fit};
   end

   // sign fix-up and result selection
   logic              neg;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fin_val;

   always_comb begin
      neg      = sign_a ^ sign_b;
      prod_fix = neg ? -prod : prod;
      quo_fix  = neg ? -quo : quo;
      rem_fix  = sign_a ? -rem[XLEN-1:0] : rem[XLEN-1:0];
      fin_val  = '0;
      case (op_q)
         OP_MUL:                      fin_val = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin_val = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU: begin
            if (b_zero)   fin_val = '1;
            else if (ovf) fin_val = MIN_NEG;
            else          fin_val = quo_fix;
         end
         OP_REM, OP_REMU: begin
            if (b_zero)   fin_val = a_q;
            else if (ovf) fin_val = '0;
            else          fin_val = rem_fix;
         end
         default:         fin_val = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = CALC;
         CALC: begin
            busy = 1'b1;
            if (cnt == CW'(XLEN-1)) state_nxt = FIN;
         end
         FIN: begin
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         done   <= 1'b0;
         result <= '0;
         cnt    <= '0;
         op_q   <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
         ovf    <= 1'b0;
         a_q    <= '0;
         mag_b  <= '0;
         quo    <= '0;
         rem    <= '0;
         prod   <= '0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q   <= op;
                  sign_a <= sa_in;
                  sign_b <= sb_in;
                  b_zero <= (b == '0);
                  ovf    <= ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
                  a_q    <= a;
                  mag_b  <= mag_b_in;
                  quo    <= mag_a_in;
                  rem    <= '0;
                  prod   <= {{XLEN{1'b0}}, mag_a_in};
                  cnt    <= '0;
               end
            end
            CALC: begin
               if (op_q[2]) begin
                  rem <= rem_step;
                  quo <= quo_step;
               end else begin
                  prod <= prod_step;
               end
               cnt <= cnt + 1'b1;
            end
            FIN: begin
               result <= fin_val;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, handshake/reset scenarios
// and randomized operations against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_hold = '0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint          sx, sy, r;
      longint unsigned ux, uy, ur;
      logic [63:0]     p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'b0, x};
      uy = {32'b0, y};
      case (o)
         3'd0: begin ur = ux * uy; p = ur; return p[31:0]; end
         3'd1: begin r = sx * sy; p = r; return p[63:32]; end
         3'd2: begin r = sx * longint'(uy); p = r; return p[63:32]; end
         3'd3: begin ur = ux * uy; p = ur; return p[63:32]; end
         3'd4: begin
            if (y == 32'd0) return 32'hFFFF_FFFF;
            r = sx / sy; p = r; return p[31:0];
         end
         3'd5: begin
            if (y == 32'd0) return 32'hFFFF_FFFF;
            return x / y;
         end
         3'd6: begin
            if (y == 32'd0) return x;
            r = sx % sy; p = r; return p[31:0];
         end
         default: begin
            if (y == 32'd0) return x;
            return x % y;
         end
      endcase
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
   endtask

   // counts edges since E0; flags busy dropping or result moving before done
   task automatic wait_done(input string tag, input int already, output logic [31:0] res, output int lat);
      logic busy_ok, hold_ok;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      lat = already;
      res = 'x;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         lat++;
         if (done) begin
            res = result;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         if (result !== exp_hold) hold_ok = 1'b0;
      end
      check_val({tag, " busy_held"}, {31'b0, busy_ok}, 32'd1);
      check_val({tag, " result_held"}, {31'b0, hold_ok}, 32'd1);
      check_val({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] exp);
      logic [31:0] res;
      int lat;
      issue(o, x, y);
      wait_done(tag, 0, res, lat);
      check_val({tag, " result"}, res, exp);
      check_val({tag, " latency"}, lat, 32'd33);
      exp_hold = exp;
      @(posedge clk); #1;
      check_val({tag, " done_pulse"}, {31'b0, done}, 32'd0);
      check_val({tag, " result_after"}, result, exp);
   endtask

   typedef struct {
      string       tag;
      logic [2:0]  o;
      logic [31:0] x, y, e;
   } vec_t;

   vec_t dir[$];

   initial begin
      logic [31:0] res, exp;
      int lat, n_done;
      logic [2:0] o;
      logic [31:0] x, y;

      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset busy", {31'b0, busy}, 32'd0);
      check_val("reset done", {31'b0, done}, 32'd0);
      check_val("reset result", result, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      dir.push_back('{"mul",        3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB});
      dir.push_back('{"mulh_small", 3'd1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF});
      dir.push_back('{"mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
      dir.push_back('{"mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
      dir.push_back('{"mulhsu",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
      dir.push_back('{"div_neg",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD});
      dir.push_back('{"rem_neg",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF});
      dir.push_back('{"divu",       3'd5, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC});
      dir.push_back('{"remu",       3'd7, 32'hFFFF_FFF9, 32'd2,        32'd1});
      dir.push_back('{"divu_zero",  3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF});
      dir.push_back('{"remu_zero",  3'd7, 32'd5,        32'd0,        32'd5});
      dir.push_back('{"div_zero",   3'd4, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF});
      dir.push_back('{"rem_zero",   3'd6, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9});
      dir.push_back('{"div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
      dir.push_back('{"rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0});
      foreach (dir[i]) run(dir[i].tag, dir[i].o, dir[i].x, dir[i].y, dir[i].e);

      // start pulsed mid-calculation must be ignored
      issue(3'd0, 32'd1000, 32'd3);
      repeat (5) begin @(posedge clk); #1; end
      op = 3'd5; a = 32'd77; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("midstart", 6, res, lat);
      check_val("midstart result", res, 32'd3000);
      check_val("midstart latency", lat, 32'd33);
      exp_hold = 32'd3000;
      n_done = 0;
      repeat (40) begin @(posedge clk); #1; if (done) n_done++; end
      check_val("midstart no_extra_done", n_done, 32'd0);

      // back-to-back: second start in the done cycle
      issue(3'd4, 32'd100, 32'hFFFF_FFF9);
      wait_done("b2b_first", 0, res, lat);
      check_val("b2b_first result", res, 32'hFFFF_FFF2);
      check_val("b2b_first latency", lat, 32'd33);
      exp_hold = 32'hFFFF_FFF2;
      issue(3'd6, 32'd100, 32'hFFFF_FFF9);
      wait_done("b2b_second", 0, res, lat);
      check_val("b2b_second result", res, 32'd2);
      check_val("b2b_second latency", lat, 32'd33);
      exp_hold = 32'd2;
      @(posedge clk); #1;

      // reset during CALC aborts
      issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (10) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_val("abort busy", {31'b0, busy}, 32'd0);
      check_val("abort done", {31'b0, done}, 32'd0);
      check_val("abort result", result, 32'd0);
      exp_hold = '0;
      n_done = 0;
      repeat (40) begin @(posedge clk); #1; if (done) n_done++; end
      check_val("abort no_done", n_done, 32'd0);
      check_val("abort result_stays", result, 32'd0);
      run("after_reset", 3'd1, 32'hFFFF_0000, 32'h0001_0000, ref_md(3'd1, 32'hFFFF_0000, 32'h0001_0000));

      for (int i = 0; i < 150; i++) begin
         o = 3'($urandom);
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            2: begin x = 32'($urandom_range(0, 40)); y = 32'($urandom_range(0, 9)) - 32'd4; end
            3: y = y >> $urandom_range(0, 31);
            default: ;
         endcase
         exp = ref_md(o, x, y);
         run($sformatf("rnd%0d op%0d", i, o), o, x, y, exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
